// File: rtl/ramen_timer_ctrl.sv
// ramen_timer_ctrl: M:SS BCD countdown controller for the ramen timer.
// Runs the IDLE/RUN/PAUSE/ALARM sequence from debounced button pulses.
// It also derives the 1 s tick and scans the three digits onto one BCD bus.
// Optional feature macro: RAMEN_TIMER_BLINK_EN blinks the display in ALARM and PAUSE.
module ramen_timer_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SCAN_DIV    = 50_000,
    parameter int DEFAULT_MIN = 3,
    parameter int ALARM_SEC   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_clear,
    output logic [3:0] bcd_min,
    output logic [3:0] bcd_sec_t,
    output logic [3:0] bcd_sec_u,
    output logic [2:0] scan_sel,
    output logic [3:0] scan_bcd,
    output logic       scan_blank,
    output logic       running,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AW = $clog2(ALARM_SEC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
    localparam logic [3:0]    RESET_MIN  = 4'(DEFAULT_MIN);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state_q, state_d;
    logic [3:0]    min_q, min_d, sect_q, sect_d, secu_q, secu_d;
    logic [3:0]    pmin_q, pmin_d, psect_q, psect_d, psecu_q, psecu_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [SW-1:0] scan_cnt_q;
    logic [2:0]    scan_sel_q;
    logic [3:0]    dec_m, dec_t, dec_u;
    logic          tick, dec_zero, time_zero, any_btn, scan_term;

    assign tick      = ((state_q == RUN) || (state_q == ALARM)) && (presc_q == PRESC_LAST);
    assign time_zero = (min_q == 4'd0) && (sect_q == 4'd0) && (secu_q == 4'd0);
    assign dec_zero  = (dec_m == 4'd0) && (dec_t == 4'd0) && (dec_u == 4'd0);
    assign any_btn   = btn_start | btn_min | btn_sec | btn_clear;
    assign scan_term = (scan_cnt_q == SCAN_LAST);

    // One-second BCD decrement with borrow from units to tens to minutes
    always_comb begin
        dec_u = secu_q - 4'd1;
        dec_t = sect_q;
        dec_m = min_q;
        if (secu_q == 4'd0) begin
            dec_u = 4'd9;
            if (sect_q == 4'd0) begin
                dec_t = 4'd5;
                dec_m = min_q - 4'd1;
            end else begin
                dec_t = sect_q - 4'd1;
            end
        end
    end

    // Next-state, time, preset, prescaler and alarm-counter logic
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sect_d  = sect_q;
        secu_d  = secu_q;
        pmin_d  = pmin_q;
        psect_d = psect_q;
        psecu_d = psecu_q;
        presc_d = presc_q;
        acnt_d  = acnt_q;
        case (state_q)
            IDLE: begin
                if (btn_clear) begin
                    min_d  = 4'd0;
                    sect_d = 4'd0;
                    secu_d = 4'd0;
                end else if (btn_start) begin
                    if (!time_zero) begin
                        pmin_d  = min_q;
                        psect_d = sect_q;
                        psecu_d = secu_q;
                        presc_d = '0;
                        state_d = RUN;
                    end
                end else if (btn_min) begin
                    min_d = (min_q == 4'd9) ? 4'd0 : min_q + 4'd1;
                end else if (btn_sec) begin
                    sect_d = (sect_q == 4'd5) ? 4'd0 : sect_q + 4'd1;
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (btn_clear) begin
                    state_d = IDLE;
                    min_d   = pmin_q;
                    sect_d  = psect_q;
                    secu_d  = psecu_q;
                end else begin
                    if (tick) begin
                        min_d  = dec_m;
                        sect_d = dec_t;
                        secu_d = dec_u;
                    end
                    if (tick && dec_zero) begin
                        state_d = ALARM;
                        acnt_d  = '0;
                    end else if (btn_start) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (btn_clear) begin
                    state_d = IDLE;
                    min_d   = pmin_q;
                    sect_d  = psect_q;
                    secu_d  = psecu_q;
                end else if (btn_start) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    acnt_d = acnt_q + 1'b1;
                end
                if (any_btn || (tick && (acnt_q == ALARM_LAST))) begin
                    state_d = IDLE;
                    min_d   = pmin_q;
                    sect_d  = psect_q;
                    secu_d  = psecu_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            min_q   <= RESET_MIN;
            sect_q  <= 4'd0;
            secu_q  <= 4'd0;
            pmin_q  <= RESET_MIN;
            psect_q <= 4'd0;
            psecu_q <= 4'd0;
            presc_q <= '0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sect_q  <= sect_d;
            secu_q  <= secu_d;
            pmin_q  <= pmin_d;
            psect_q <= psect_d;
            psecu_q <= psecu_d;
            presc_q <= presc_d;
            acnt_q  <= acnt_d;
        end
    end

    // Free-running scan slot counter and one-hot digit rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            scan_sel_q <= 3'b001;
        end else if (scan_term) begin
            scan_cnt_q <= '0;
            scan_sel_q <= {scan_sel_q[1:0], scan_sel_q[2]};
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // Route the selected digit of the current time onto the scan bus
    always_comb begin
        case (scan_sel_q)
            3'b001:  scan_bcd = secu_q;
            3'b010:  scan_bcd = sect_q;
            3'b100:  scan_bcd = min_q;
            default: scan_bcd = 4'd0;
        endcase
    end

`ifdef RAMEN_TIMER_BLINK_EN
    logic [7:0] rot_cnt_q;

    // Count scan rotations; bit 7 gives a slow blink rate for PAUSE
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_cnt_q <= 8'd0;
        end else if (scan_term) begin
            rot_cnt_q <= rot_cnt_q + 8'd1;
        end
    end

    assign scan_blank = ((state_q == ALARM) && (presc_q >= PW'(TICK_DIV / 2)))
                      || ((state_q == PAUSE) && rot_cnt_q[7]);
`else
    assign scan_blank = 1'b0;
`endif

    assign scan_sel  = scan_sel_q;
    assign bcd_min   = min_q;
    assign bcd_sec_t = sect_q;
    assign bcd_sec_u = secu_q;
    assign running   = (state_q == RUN);
    assign alarm     = (state_q == ALARM);

endmodule

// File: tb/tb_ramen_timer_ctrl.sv
// tb_ramen_timer_ctrl: directed bench for ramen_timer_ctrl with a fast tick
// (4 cycles), 2-cycle scan slots, 3-minute default and 2-tick alarm.
module tb_ramen_timer_ctrl;

    localparam int SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0, btn_min = 1'b0, btn_sec = 1'b0, btn_clear = 1'b0;
    logic [3:0] bcd_min, bcd_sec_t, bcd_sec_u, scan_bcd;
    logic [2:0] scan_sel;
    logic       scan_blank, running, alarm;

    int         n_vec  = 0;
    int         n_miss = 0;
    int         m_scan_cnt = 0;
    logic [2:0] m_scan_sel = 3'b001;

    typedef struct {
        logic       start, mn, sc, clr;
        logic       er, ea;
        logic [3:0] em, et, eu;
    } vec_t;

    vec_t vecs[19];

    ramen_timer_ctrl #(
        .TICK_DIV(4), .SCAN_DIV(SCAN_DIV), .DEFAULT_MIN(3), .ALARM_SEC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_min(btn_min), .btn_sec(btn_sec), .btn_clear(btn_clear),
        .bcd_min(bcd_min), .bcd_sec_t(bcd_sec_t), .bcd_sec_u(bcd_sec_u),
        .scan_sel(scan_sel), .scan_bcd(scan_bcd), .scan_blank(scan_blank),
        .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it in, advance the scan reference, release inputs
    task automatic applyStimulus(input logic s, input logic m, input logic se,
                                 input logic c, input logic r);
        btn_start = s; btn_min = m; btn_sec = se; btn_clear = c; rst = r;
        @(posedge clk);
        if (r) begin
            m_scan_cnt = 0;
            m_scan_sel = 3'b001;
        end else if (m_scan_cnt == SCAN_DIV - 1) begin
            m_scan_cnt = 0;
            m_scan_sel = {m_scan_sel[1:0], m_scan_sel[2]};
        end else begin
            m_scan_cnt++;
        end
        #1;
        btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0; btn_clear = 1'b0; rst = 1'b0;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic er, input logic ea,
                               input logic [3:0] em, input logic [3:0] et, input logic [3:0] eu);
        n_vec++;
        if ({running, alarm, bcd_min, bcd_sec_t, bcd_sec_u} !== {er, ea, em, et, eu}) begin
            n_miss++;
            $display("[TB] FAIL %s: got run=%b alarm=%b %h:%h%h, expected run=%b alarm=%b %h:%h%h",
                     name, running, alarm, bcd_min, bcd_sec_t, bcd_sec_u, er, ea, em, et, eu);
        end
    endtask

    task automatic checkScan(input string name, input logic [3:0] em,
                             input logic [3:0] et, input logic [3:0] eu, input logic eblank);
        logic [3:0] ebcd;
        ebcd = (m_scan_sel == 3'b001) ? eu : (m_scan_sel == 3'b010) ? et : em;
        n_vec++;
        if ({scan_sel, scan_bcd, scan_blank} !== {m_scan_sel, ebcd, eblank}) begin
            n_miss++;
            $display("[TB] FAIL %s: got sel=%b bcd=%h blank=%b, expected sel=%b bcd=%h blank=%b",
                     name, scan_sel, scan_bcd, scan_blank, m_scan_sel, ebcd, eblank);
        end
    endtask

    initial begin
        // IDLE editing vectors, starting from the 3:00 reset value
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 4'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 4'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd4, 4'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd5, 4'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 4'd0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0};

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, 1'b0, 4'd3, 4'd0, 4'd0);
        checkScan("reset_scan", 4'd3, 4'd0, 4'd0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].start, vecs[i].mn, vecs[i].sc, vecs[i].clr, 1'b0);
            checkOutput($sformatf("idle_vec%0d", i), vecs[i].er, vecs[i].ea,
                        vecs[i].em, vecs[i].et, vecs[i].eu);
        end

        // 0:10 countdown to natural alarm expiry
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("a_start", 1'b1, 1'b0, 4'd0, 4'd1, 4'd0);
        runIdle(3);
        checkOutput("a_pre_tick", 1'b1, 1'b0, 4'd0, 4'd1, 4'd0);
        runIdle(1);
        checkOutput("a_first_tick", 1'b1, 1'b0, 4'd0, 4'd0, 4'd9);
        runIdle(35);
        checkOutput("a_at_0_01", 1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
        runIdle(1);
        checkOutput("a_alarm", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        checkScan("a_alarm_scan", 4'd0, 4'd0, 4'd0, 1'b0);
        runIdle(7);
        checkOutput("a_alarm_last", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        runIdle(1);
        checkOutput("a_expired", 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);

        // Alarm aborted by a button pulse
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(40);
        checkOutput("b_alarm", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("b_btn_exit", 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);

        // Start pulse coincident with the final tick goes to ALARM
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(36);
        checkOutput("c_at_0_01", 1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
        runIdle(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("c_tick_start", 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c_clear_exit", 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);

        // Clear wins over start while running
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(5);
        checkOutput("d_running", 1'b1, 1'b0, 4'd0, 4'd0, 4'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("d_clear_start", 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);

        // Reset in the middle of a run
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("e_rst_run", 1'b0, 1'b0, 4'd3, 4'd0, 4'd0);
        checkScan("e_rst_scan", 4'd3, 4'd0, 4'd0, 1'b0);

        // Pause on the fourth tick, hold, resume for a full tick period
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(15);
        checkOutput("f_2_57", 1'b1, 1'b0, 4'd2, 4'd5, 4'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("f_pause", 1'b0, 1'b0, 4'd2, 4'd5, 4'd6);
        runIdle(100);
        checkOutput("f_frozen", 1'b0, 1'b0, 4'd2, 4'd5, 4'd6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(3);
        checkOutput("f_resume_hold", 1'b1, 1'b0, 4'd2, 4'd5, 4'd6);
        runIdle(1);
        checkOutput("f_resume_tick", 1'b1, 1'b0, 4'd2, 4'd5, 4'd5);

        // Pause then clear restores the preset
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("g_pause_clear", 1'b0, 1'b0, 4'd3, 4'd0, 4'd0);

        // Build 7:50, count down to 7:42 and pause there for the scan check
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("g_7_50", 1'b0, 1'b0, 4'd7, 4'd5, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(31);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("g_7_42", 1'b0, 1'b0, 4'd7, 4'd4, 4'd2);
        for (int i = 0; i < 6; i++) begin
            runIdle(1);
            checkScan($sformatf("g_scan%0d", i), 4'd7, 4'd4, 4'd2, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("g_pause_min_ignored", 1'b0, 1'b0, 4'd7, 4'd4, 4'd2);

        // Resume and reset while running
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runIdle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("h_rst_run", 1'b0, 1'b0, 4'd3, 4'd0, 4'd0);
        checkScan("h_rst_scan", 4'd3, 4'd0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
